clk_div_monitor: RTL
====================

Name: clk_div_monitor

Overview:
- Downstream checker for the programmable clock divider output; runs on the source clock and watches the divided clock as a sampled data signal.
- Measures period and high time in source-clock cycles, compares the period against the expected divisor, and reports per-period errors, lock status and loss-of-clock timeout.
- Used for bring-up self-check and for runtime supervision of the divided clock.

Parameters:
- CNT_W, 16, width of divisor, period and high-time counters.
- SYNC_STAGES, 2, flops in the div_in synchronizer; minimum 2.
- LOCK_CNT, 4, consecutive matching periods needed to assert locked; range 1..255.

Ports:
- clk  in  1  source clock, the same clock that feeds the divider.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  monitor enable.
- div_in  in  1  divided clock under test.
- exp_n  in  CNT_W  expected divisor in source-clock cycles.
- meas_period  out  CNT_W  last measured period.
- meas_high  out  CNT_W  last measured high time.
- meas_valid  out  1  one-cycle pulse; meas_period is newly updated.
- err  out  1  one-cycle pulse with meas_valid when meas_period != exp_n.
- locked  out  1  period matched exp_n for LOCK_CNT consecutive periods.
- timeout  out  1  no rising edge seen for 2^CNT_W-1 cycles.

Behaviour:
- Reset: when rst is low, all flops clear immediately. This includes the sync chain, counters, armed, match_cnt, and every output (meas_period, meas_high, meas_valid, err, locked, timeout all 0). Release is sampled on the clk rising edge.
- Synchronizer and edges:
  - div_in passes through SYNC_STAGES flops; s is the last stage, s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- Period counter per_cnt (CNT_W bits):
  - On rise, per_cnt <= 1.
  - Otherwise per_cnt <= per_cnt+1, saturating at all-ones.
  - For rises N cycles apart, per_cnt == N at the second rise.
- High counter hi_cnt:
  - On rise, hi_cnt <= 1.
  - While s is high and there is no rise, increment, saturating.
  - On fall, meas_high <= hi_cnt.
  - For odd N the divider output is high for (N>>1)+0.5 cycles, so the sampled high time is N>>1 or (N>>1)+1. No error is raised on high time.
- armed flag:
  - Set by the first rise after reset, after en rises, or after a timeout.
  - That first rise only arms. No capture, no meas_valid.
- Capture: on rise with armed=1:
  - meas_period <= per_cnt; meas_valid <= 1 for one cycle.
  - err <= (per_cnt != exp_n).
- Latency: div_in first sampled high at edge k gives meas_valid/err high after edge k+SYNC_STAGES, for exactly one cycle.
- Lock counter match_cnt (8 bits):
  - On capture with match, increment, saturating at LOCK_CNT.
  - On capture with mismatch, clear to 0.
  - locked = registered (match_cnt == LOCK_CNT), updated on the same edge as meas_valid.
- exp_n change: exp_n is registered; any change clears match_cnt and locked on the next edge. Meas registers are not affected.
- Timeout: when per_cnt reaches all-ones:
  - timeout <= 1, armed <= 0, match_cnt <= 0, locked <= 0.
  - timeout stays high until the next rise. That rise clears timeout and re-arms only.
- en=0:
  - Clears per_cnt, hi_cnt, armed, match_cnt, locked, timeout.
  - Holds meas_period and meas_high.
  - No meas_valid/err.
  - The sync chain keeps running.
- Simultaneous events:
  - Capture-mismatch and exp_n change in the same cycle both clear.
  - A rise in the same cycle per_cnt saturates counts as a rise. No timeout is set and no capture is made (saturated value is invalid).
- Period 1 or constant div_in: no edges, so only timeout can occur.

Test Plan:
- div_in period 8 (4 high/4 low), exp_n=8, en=1 → no valid on 1st rise; from 2nd rise meas_valid each period with meas_period=8, meas_high=4, err=0; locked=1 on the 4th capture.
- After lock, insert one period of 9 then resume 8 → err pulses once with meas_period=9, locked drops on that capture, relocks after 4 further captures.
- exp_n=8, div_in period 10 → err on every capture; locked stays 0. Change exp_n to 10 → locked after 4 captures. Change exp_n to 12 while locked → locked=0 one cycle later.
- Odd divisor: period 7 with high 4 → meas_period=7, meas_high=4, err=0 with exp_n=7.
- Lock, then hold div_in=0 → timeout=1 and locked=0 once per_cnt saturates at 65535. Restart toggling → first rise clears timeout with no meas_valid; second rise gives a valid capture.
- Assert rst low mid-period while locked → all outputs 0 asynchronously, before the next clk edge. After release, the first rise arms only.

Source files
------------

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
//
// Supervises the output of a programmable clock divider. Runs on the divider's
// source clock and treats the divided clock as an ordinary data input. The
// monitor measures its period and high time in source-clock cycles, compares
// the period against the expected divisor, and tracks lock and loss of clock.
//
// Ports
//   clk          source clock (the divider's input clock)
//   rst          asynchronous, active-low reset
//   en           monitor enable; low clears measurement state but not results
//   div_in       divided clock under test (asynchronous to the monitor logic)
//   exp_n        expected divisor in source-clock cycles
//   meas_period  last measured period
//   meas_high    last measured high time
//   meas_valid   one-cycle pulse when meas_period is updated
//   err          one-cycle pulse, with meas_valid, when the period != exp_n
//   locked       LOCK_CNT consecutive captured periods matched exp_n
//   timeout      no rising edge for 2^CNT_W-1 cycles; held until the next rise
// -----------------------------------------------------------------------------
module clk_div_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_n,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             err,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       LOCK_MAX = 8'(LOCK_CNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_W-1:0]       exp_q;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
  logic                   armed_q, armed_d;
  logic [7:0]             match_q, match_d;
  logic [CNT_W-1:0]       meas_period_q, meas_period_d;
  logic [CNT_W-1:0]       meas_high_q, meas_high_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   err_q, err_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;

  logic s, rise, fall, per_sat, exp_chg;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign per_sat = (per_cnt_q == CNT_MAX);
  assign exp_chg = (exp_n != exp_q);

  always_comb begin
    per_cnt_d     = per_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    armed_d       = armed_q;
    match_d       = match_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_valid_d  = 1'b0;
    err_d         = 1'b0;
    timeout_d     = timeout_q;

    if (!en) begin
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      armed_d   = 1'b0;
      match_d   = '0;
      timeout_d = 1'b0;
    end else begin
      if (rise) begin
        per_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        hi_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        armed_d   = 1'b1;
        timeout_d = 1'b0;
        // A saturated period count is not a real measurement, so a rise that
        // lands on it only re-arms.
        if (armed_q && !per_sat) begin
          meas_period_d = per_cnt_q;
          meas_valid_d  = 1'b1;
          err_d         = (per_cnt_q != exp_n);
          if (per_cnt_q == exp_n) begin
            match_d = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + 8'd1;
          end else begin
            match_d = '0;
          end
        end
      end else begin
        if (!per_sat) begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
        if (s && (hi_cnt_q != CNT_MAX)) begin
          hi_cnt_d = hi_cnt_q + 1'b1;
        end
        // Loss of clock: drop the lock and require a fresh arming rise.
        if (per_sat) begin
          timeout_d = 1'b1;
          armed_d   = 1'b0;
          match_d   = '0;
        end
      end

      if (fall) begin
        meas_high_d = hi_cnt_q;
      end

      // A new target divisor invalidates any lock history.
      if (exp_chg) begin
        match_d = '0;
      end
    end

    locked_d = (match_d == LOCK_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q        <= '0;
      s_d_q         <= 1'b0;
      exp_q         <= '0;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      armed_q       <= 1'b0;
      match_q       <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], div_in};
      s_d_q         <= s;
      exp_q         <= exp_n;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      armed_q       <= armed_d;
      match_q       <= match_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_valid_q  <= meas_valid_d;
      err_q         <= err_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
    end
  end

  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign meas_valid  = meas_valid_q;
  assign err         = err_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule
